// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory stall controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } dmem_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned BE_W       = DATA_W_DEF / 8;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clear/enable saturating cycle counter; 'hit' flags the last permitted cycle.
module dmem_timeout_cnt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  generate
    if (LIMIT == 0) begin : g_off
      assign hit = 1'b0;
    end else begin : g_cnt
      localparam int unsigned W = $clog2(LIMIT + 1);
      localparam logic [W-1:0] TOP  = W'(LIMIT);
      localparam logic [W-1:0] LAST = W'(LIMIT - 1);

      logic [W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != TOP)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign hit = en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory controller: turns a load/store into a bus request/response
// and holds stall_all until the access completes.
module dmem_stall_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                stall_all,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_rdata,
  input  logic                bus_rsp_err
);

  dmem_state_e state;
  logic        to_hit;
  logic        mem_req;

  assign mem_req = mem_read | mem_write;

  dmem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state != WAIT_RSP),
    .en      (state == WAIT_RSP),
    .hit     (to_hit)
  );

  // IDLE term is gated by reset so a held request cannot stall while in reset.
  always_comb begin
    stall_all = 1'b0;
    case (state)
      IDLE:     stall_all = reset_n & mem_req;
      REQ:      stall_all = 1'b1;
      WAIT_RSP: stall_all = 1'b1;
      default:  stall_all = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_be        <= '0;
      mem_rdata     <= '0;
      mem_err       <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            bus_we        <= mem_write & ~mem_read;
            bus_addr      <= mem_addr;
            bus_wdata     <= mem_wdata;
            bus_be        <= mem_be;
            bus_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response arriving on the timeout cycle still wins over the abort.
          if (bus_rsp_valid) begin
            if (bus_rsp_err) begin
              mem_rdata <= '0;
              mem_err   <= 1'b1;
            end else if (!bus_we) begin
              mem_rdata <= bus_rsp_rdata;
            end
            state <= DONE;
          end else if (to_hit) begin
            mem_rdata <= '0;
            mem_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus_req_valid <= 1'b0;
        end
      endcase
    end
  end

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl with a cycle-stepped bus responder.
module tb_dmem_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        stall_all;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        bus_req_valid, bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_stall_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .stall_all     (stall_all),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_be        (bus_be),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one access, acts as the bus, and runs through DONE plus one cycle.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  int          ready_wait,
    input  int          rsp_wait,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    input  logic        respond,
    output int          stall_cnt,
    output int          accepts,
    output int          payload_bad,
    output int          err_pulses,
    output logic [31:0] rdata_done,
    output int          done_seen
  );
    int rdy_cnt;
    int rsp_at;
    int post;
    mem_read    = rd;
    mem_write   = wr;
    mem_addr    = addr;
    mem_wdata   = wdata;
    mem_be      = be;
    stall_cnt   = 0;
    accepts     = 0;
    payload_bad = 0;
    err_pulses  = 0;
    rdata_done  = '0;
    done_seen   = 0;
    rdy_cnt     = 0;
    rsp_at      = -1;
    post        = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      bus_rsp_valid = respond && (c == rsp_at);
      bus_rsp_rdata = rsp_data;
      bus_rsp_err   = rsp_err;
      if (stall_all) stall_cnt++;
      if (mem_err) err_pulses++;
      if (bus_req_valid) begin
        if (bus_addr !== addr || bus_wdata !== wdata || bus_be !== be ||
            bus_we !== (wr & ~rd))
          payload_bad++;
        if (rdy_cnt >= ready_wait) begin
          bus_req_ready = 1'b1;
          accepts++;
          rsp_at = c + 1 + rsp_wait;
        end else begin
          bus_req_ready = 1'b0;
          rdy_cnt++;
        end
      end else begin
        bus_req_ready = 1'b0;
      end
      if (done_seen == 0 && !stall_all && stall_cnt > 0) begin
        done_seen  = 1;
        rdata_done = mem_rdata;
      end
      @(posedge clk);
      #1;
      if (done_seen != 0) begin
        if (post != 0) break;
        post      = 1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
  endtask

  int          st, acc, pbad, errs, dn;
  logic [31:0] rdv;

  initial begin
    reset_n       = 1'b0;
    mem_read      = 1'b1;
    mem_write     = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_be        = 4'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'h0;
    bus_rsp_err   = 1'b0;

    // 1. reset held with a load pending
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_all), 64'h0);
    chk("rst_valid", 64'(bus_req_valid), 64'h0);
    chk("rst_rdata", 64'(mem_rdata), 64'h0);
    chk("rst_err", 64'(mem_err), 64'h0);
    mem_read = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // 2. load on a zero-wait bus
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 1'b0, 1'b1,
               st, acc, pbad, errs, rdv, dn);
    chk("ld_done", 64'(dn), 64'd1);
    chk("ld_stall", 64'(st), 64'd3);
    chk("ld_accepts", 64'(acc), 64'd1);
    chk("ld_payload", 64'(pbad), 64'd0);
    chk("ld_rdata", 64'(rdv), 64'hDEADBEEF);
    chk("ld_err", 64'(errs), 64'd0);

    // 3. store with 4 cycles of backpressure
    run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 4'b0011, 4, 0, 32'h55AA55AA, 1'b0, 1'b1,
               st, acc, pbad, errs, rdv, dn);
    chk("st_done", 64'(dn), 64'd1);
    chk("st_stall", 64'(st), 64'd7);
    chk("st_accepts", 64'(acc), 64'd1);
    chk("st_payload", 64'(pbad), 64'd0);
    chk("st_rdata_kept", 64'(rdv), 64'hDEADBEEF);
    chk("st_err", 64'(errs), 64'd0);

    // 4. load answered with a bus error
    run_access(1'b1, 1'b0, 32'h108, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, 1'b1, 1'b1,
               st, acc, pbad, errs, rdv, dn);
    chk("be_done", 64'(dn), 64'd1);
    chk("be_stall", 64'(st), 64'd4);
    chk("be_rdata", 64'(rdv), 64'h0);
    chk("be_err", 64'(errs), 64'd1);

    // refill rdata so the timeout clear is observable
    run_access(1'b1, 1'b0, 32'h10C, 32'h0, 4'hF, 0, 0, 32'h0BADC0DE, 1'b0, 1'b1,
               st, acc, pbad, errs, rdv, dn);
    chk("pre_to_rdata", 64'(rdv), 64'h0BADC0DE);

    // 5. timeout: accepted, never answered -> 8 cycles in WAIT_RSP
    run_access(1'b1, 1'b0, 32'h110, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0,
               st, acc, pbad, errs, rdv, dn);
    chk("to_done", 64'(dn), 64'd1);
    chk("to_stall", 64'(st), 64'd10);
    chk("to_accepts", 64'(acc), 64'd1);
    chk("to_rdata", 64'(rdv), 64'h0);
    chk("to_err", 64'(errs), 64'd1);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hFFFFFFFF;
    bus_rsp_err   = 1'b1;
    #1;
    chk("late_stall", 64'(stall_all), 64'h0);
    @(posedge clk);
    #1;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    chk("late_err", 64'(mem_err), 64'h0);
    chk("late_rdata", 64'(mem_rdata), 64'h0);
    chk("late_valid", 64'(bus_req_valid), 64'h0);

    // 6. reset while waiting for a response
    mem_read      = 1'b1;
    mem_addr      = 32'h400;
    bus_req_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_req_valid", 64'(bus_req_valid), 64'h1);
    @(posedge clk);
    #1;
    bus_req_ready = 1'b0;
    chk("mr_wait_stall", 64'(stall_all), 64'h1);
    reset_n  = 1'b0;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_stall", 64'(stall_all), 64'h0);
    chk("mr_valid", 64'(bus_req_valid), 64'h0);
    chk("mr_err", 64'(mem_err), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_idle_stall", 64'(stall_all), 64'h0);
    chk("mr_idle_err", 64'(mem_err), 64'h0);
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 0, 0, 32'hA5A5A5A5, 1'b0, 1'b1,
               st, acc, pbad, errs, rdv, dn);
    chk("mr_ld_done", 64'(dn), 64'd1);
    chk("mr_ld_stall", 64'(st), 64'd3);
    chk("mr_ld_payload", 64'(pbad), 64'd0);
    chk("mr_ld_rdata", 64'(rdv), 64'hA5A5A5A5);
    chk("mr_ld_err", 64'(errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
